regfile_issue_ctrl: RTL



---
 rtl/rv32ima_pkg.sv | 19 +
 rtl/regfile_scoreboard.sv | 43 ++++
 rtl/regfile_issue_ctrl.sv | 126 ++++++++++++
 3 files changed

// File: rtl/rv32ima_pkg.sv
// Shared RV32 types plus the scoreboard width and a one-hot helper
// used by the issue controller.
package rv32ima_pkg;

    typedef logic [4:0]  reg_t;
    typedef logic [31:0] word_t;

    localparam int REG_CNT = 32;

    typedef logic [REG_CNT-1:0] scoreboard_t;

    function automatic scoreboard_t regMask(input reg_t r);
        scoreboard_t m;
        m    = '0;
        m[r] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-destination scoreboard: one busy bit per architectural register.
// A set and a clear aimed at the same register in one cycle leave it busy.
module regfile_scoreboard
    import rv32ima_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        set_en,
    input  reg_t        set_idx,
    input  logic        clr_en,
    input  reg_t        clr_idx,
    output scoreboard_t busy
);

    scoreboard_t busy_q, busy_d;

    // Clear is applied before set so a re-issue to the retiring register stays busy.
    always_comb begin
        busy_d = busy_q;
        if (clr_en) begin
            busy_d = busy_d & ~regMask(clr_idx);
        end
        if (set_en) begin
            busy_d = busy_d | regMask(set_idx);
        end
        if (flush) begin
            busy_d = '0;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy = busy_q;

endmodule

// File: rtl/regfile_issue_ctrl.sv
// Issue stage between decode and execute: reads operands with writeback
// bypass, stalls on RAW/WAW hazards and registers the operand bundle.
module regfile_issue_ctrl
    import rv32ima_pkg::*;
#(
    parameter bit BYPASS_EN = 1'b1,
    parameter bit WAW_STALL = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  reg_t        issue_rs1,
    input  reg_t        issue_rs2,
    input  reg_t        issue_rd,
    input  logic        issue_rd_en,
    output reg_t        rsel1,
    output reg_t        rsel2,
    input  word_t       rdat1,
    input  word_t       rdat2,
    output reg_t        wsel,
    output logic        wen,
    output word_t       wdat,
    input  logic        wb_valid,
    input  reg_t        wb_rd,
    input  word_t       wb_data,
    output logic        op_valid,
    input  logic        op_ready,
    output word_t       op_rs1_val,
    output word_t       op_rs2_val,
    output reg_t        op_rd,
    output logic        op_rd_en,
    output scoreboard_t busy,
    output logic        wb_err
);

    logic  op_valid_q, op_valid_d;
    word_t op_rs1_q, op_rs1_d;
    word_t op_rs2_q, op_rs2_d;
    reg_t  op_rd_q, op_rd_d;
    logic  op_rd_en_q, op_rd_en_d;
    logic  wb_err_q, wb_err_d;

    logic  byp1, byp2, haz1, haz2, hazWaw, accept, wbWrite;
    word_t rs1Val, rs2Val;

    assign rsel1   = issue_rs1;
    assign rsel2   = issue_rs2;
    assign wbWrite = wb_valid && (wb_rd != '0);
    assign wsel    = wb_rd;
    assign wdat    = wb_data;
    assign wen     = wbWrite;

    // A writeback landing this cycle resolves a RAW hazard only when bypass is enabled,
    // but always resolves a WAW hazard since the old write is retiring now.
    always_comb begin
        byp1   = BYPASS_EN && wb_valid && (wb_rd == issue_rs1);
        byp2   = BYPASS_EN && wb_valid && (wb_rd == issue_rs2);
        rs1Val = (issue_rs1 == '0) ? '0 : (byp1 ? wb_data : rdat1);
        rs2Val = (issue_rs2 == '0) ? '0 : (byp2 ? wb_data : rdat2);
        haz1   = (issue_rs1 != '0) && busy[issue_rs1] && !byp1;
        haz2   = (issue_rs2 != '0) && busy[issue_rs2] && !byp2;
        hazWaw = WAW_STALL && issue_rd_en && (issue_rd != '0) && busy[issue_rd]
                 && !(wb_valid && (wb_rd == issue_rd));
        issue_ready = !flush && (!op_valid_q || op_ready) && !haz1 && !haz2 && !hazWaw;
        accept      = issue_valid && issue_ready;
    end

    regfile_scoreboard u_scoreboard (
        .clk     (clk),
        .rst     (rst),
        .flush   (flush),
        .set_en  (accept && issue_rd_en && (issue_rd != '0)),
        .set_idx (issue_rd),
        .clr_en  (wbWrite),
        .clr_idx (wb_rd),
        .busy    (busy)
    );

    always_comb begin
        op_valid_d = op_valid_q;
        op_rs1_d   = op_rs1_q;
        op_rs2_d   = op_rs2_q;
        op_rd_d    = op_rd_q;
        op_rd_en_d = op_rd_en_q;
        if (flush) begin
            op_valid_d = 1'b0;
        end else if (accept) begin
            op_valid_d = 1'b1;
            op_rs1_d   = rs1Val;
            op_rs2_d   = rs2Val;
            op_rd_d    = issue_rd;
            op_rd_en_d = issue_rd_en;
        end else if (op_ready) begin
            op_valid_d = 1'b0;
        end
        wb_err_d = wb_err_q || (wbWrite && !busy[wb_rd] && !flush);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_valid_q <= 1'b0;
            op_rs1_q   <= '0;
            op_rs2_q   <= '0;
            op_rd_q    <= '0;
            op_rd_en_q <= 1'b0;
            wb_err_q   <= 1'b0;
        end else begin
            op_valid_q <= op_valid_d;
            op_rs1_q   <= op_rs1_d;
            op_rs2_q   <= op_rs2_d;
            op_rd_q    <= op_rd_d;
            op_rd_en_q <= op_rd_en_d;
            wb_err_q   <= wb_err_d;
        end
    end

    assign op_valid   = op_valid_q;
    assign op_rs1_val = op_rs1_q;
    assign op_rs2_val = op_rs2_q;
    assign op_rd      = op_rd_q;
    assign op_rd_en   = op_rd_en_q;
    assign wb_err     = wb_err_q;

endmodule
